// File: rtl/atm_session_ctrl_pkg.sv
// Shared types and constants for the ATM session sequencer.
package atm_session_ctrl_pkg;

  localparam int unsigned TIMER_W     = 8;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned MSG_W       = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PIN    = 3'd1,
    ST_MENU   = 3'd2,
    ST_DISP   = 3'd3,
    ST_EJECT  = 3'd4,
    ST_RETAIN = 3'd5
  } state_e;

  localparam logic [MSG_W-1:0] MSG_START    = 3'd0;
  localparam logic [MSG_W-1:0] MSG_ENTER    = 3'd1;
  localparam logic [MSG_W-1:0] MSG_MENU     = 3'd2;
  localparam logic [MSG_W-1:0] MSG_WRONG    = 3'd3;
  localparam logic [MSG_W-1:0] MSG_DISP     = 3'd4;
  localparam logic [MSG_W-1:0] MSG_NSF      = 3'd5;
  localparam logic [MSG_W-1:0] MSG_TAKE     = 3'd6;
  localparam logic [MSG_W-1:0] MSG_RETAINED = 3'd7;

  // Display code for a given state and flag set.
  function automatic logic [MSG_W-1:0] msg_for(state_e st, logic wrong, logic nsf);
    logic [MSG_W-1:0] m;
    m = MSG_START;
    case (st)
      ST_PIN:    m = wrong ? MSG_WRONG : MSG_ENTER;
      ST_MENU:   m = nsf ? MSG_NSF : MSG_MENU;
      ST_DISP:   m = MSG_DISP;
      ST_EJECT:  m = MSG_TAKE;
      ST_RETAIN: m = MSG_RETAINED;
      default:   m = MSG_START;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/session_timer.sv
// Saturating inactivity counter with synchronous clear; flags when the limit is reached.
module session_timer
  import atm_session_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam logic [TIMER_W-1:0] LIMIT_C = TIMER_W'(LIMIT);

  logic [TIMER_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LIMIT_C)) begin
      cnt_q <= cnt_q + TIMER_W'(1);
    end
  end

  assign timeout_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM card session sequencer: card detect, PIN retry, withdrawal, note dispensing,
// eject or retain. Outputs are registered from the next-state values.
module atm_session_ctrl
  import atm_session_ctrl_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned AMT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card,
  input  logic             pin_ok,
  input  logic             pin_bad,
  input  logic             cancel,
  input  logic             wd_req,
  input  logic [AMT_W-1:0] wd_amt,
  input  logic [AMT_W-1:0] balance,
  input  logic             note_ack,
  output logic             pin_clr,
  output logic             note_req,
  output logic             eject,
  output logic             retain,
  output logic [MSG_W-1:0] msg
);

  localparam logic [1:0] MAX_TRIES_C = 2'(MAX_TRIES);

  state_e             state_q, state_d;
  logic [1:0]         tries_q, tries_d;
  logic [AMT_W-1:0]   notes_q, notes_d;
  logic [AMT_W-1:0]   bal_q, bal_d;
  logic               nsf_q, nsf_d;
  logic               wrong_q, wrong_d;
  logic               pin_clr_q, pin_clr_d;
  logic               note_req_q, eject_q, retain_q;
  logic [MSG_W-1:0]   msg_q;
  logic               tmr_clr_c, tmr_en_c, timeout_c;

  assign tmr_en_c = (state_q == ST_PIN) || (state_q == ST_MENU);

  session_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr_c || !tmr_en_c),
    .en_i      (tmr_en_c),
    .timeout_o (timeout_c)
  );

  // Next-state and register updates.
  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    notes_d   = notes_q;
    bal_d     = bal_q;
    nsf_d     = nsf_q;
    wrong_d   = wrong_q;
    pin_clr_d = 1'b0;
    tmr_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (card) begin
          state_d   = ST_PIN;
          pin_clr_d = 1'b1;
          tries_d   = '0;
          wrong_d   = 1'b0;
          nsf_d     = 1'b0;
          tmr_clr_c = 1'b1;
        end
      end
      ST_PIN: begin
        if (pin_ok) begin
          state_d   = ST_MENU;
          bal_d     = balance;
          wrong_d   = 1'b0;
          nsf_d     = 1'b0;
          tmr_clr_c = 1'b1;
        end else if (pin_bad) begin
          tries_d = tries_q + 2'd1;
          if (tries_d == MAX_TRIES_C) begin
            state_d = ST_RETAIN;
          end else begin
            pin_clr_d = 1'b1;
            wrong_d   = 1'b1;
            tmr_clr_c = 1'b1;
          end
        end else if (cancel || timeout_c) begin
          state_d = ST_EJECT;
        end else if (!card) begin
          state_d = ST_IDLE;
        end
      end
      ST_MENU: begin
        if (wd_req && (wd_amt != '0)) begin
          if (wd_amt > bal_q) begin
            nsf_d     = 1'b1;
            tmr_clr_c = 1'b1;
          end else begin
            notes_d = wd_amt;
            bal_d   = bal_q - wd_amt;
            nsf_d   = 1'b0;
            state_d = ST_DISP;
          end
        end else if (cancel || timeout_c) begin
          state_d = ST_EJECT;
        end else if (!card) begin
          state_d = ST_IDLE;
        end
      end
      ST_DISP: begin
        // Cancel, timeout and card removal cannot interrupt a dispense.
        if (note_req_q && note_ack) begin
          notes_d = notes_q - AMT_W'(1);
          if (notes_d == '0) begin
            state_d   = ST_MENU;
            tmr_clr_c = 1'b1;
          end
        end
      end
      ST_EJECT: begin
        if (!card) state_d = ST_IDLE;
      end
      ST_RETAIN: begin
        state_d = ST_RETAIN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tries_q    <= '0;
      notes_q    <= '0;
      bal_q      <= '0;
      nsf_q      <= 1'b0;
      wrong_q    <= 1'b0;
      pin_clr_q  <= 1'b0;
      note_req_q <= 1'b0;
      eject_q    <= 1'b0;
      retain_q   <= 1'b0;
      msg_q      <= MSG_START;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      notes_q    <= notes_d;
      bal_q      <= bal_d;
      nsf_q      <= nsf_d;
      wrong_q    <= wrong_d;
      pin_clr_q  <= pin_clr_d;
      note_req_q <= (state_d == ST_DISP) && (notes_d != '0);
      eject_q    <= (state_d == ST_EJECT);
      retain_q   <= (state_d == ST_RETAIN);
      msg_q      <= msg_for(state_d, wrong_d, nsf_d);
    end
  end

  assign pin_clr  = pin_clr_q;
  assign note_req = note_req_q;
  assign eject    = eject_q;
  assign retain   = retain_q;
  assign msg      = msg_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl with a short inactivity limit.
module tb_atm_session_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       card = 1'b0, pin_ok = 1'b0, pin_bad = 1'b0, cancel = 1'b0;
  logic       wd_req = 1'b0, note_ack = 1'b0;
  logic [7:0] wd_amt = 8'd0, balance = 8'd0;
  logic       pin_clr, note_req, eject, retain;
  logic [2:0] msg;

  int tests = 0;
  int failed = 0;
  int cnt;

  atm_session_ctrl #(.MAX_TRIES(3), .TIMEOUT(10), .AMT_W(8)) dut (
    .clk(clk), .rst(rst), .card(card), .pin_ok(pin_ok), .pin_bad(pin_bad),
    .cancel(cancel), .wd_req(wd_req), .wd_amt(wd_amt), .balance(balance),
    .note_ack(note_ack), .pin_clr(pin_clr), .note_req(note_req),
    .eject(eject), .retain(retain), .msg(msg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Insert card and pass PIN with the given balance; ends in MENU.
  task automatic login(input logic [7:0] bal);
    card = 1'b1; step(); step();
    pin_ok = 1'b1; balance = bal; step(); pin_ok = 1'b0;
  endtask

  // Hold note_ack and count handshakes until note_req drops (bounded).
  task automatic dispense(output int n);
    n = 0;
    note_ack = 1'b1;
    for (int i = 0; i < 40 && note_req; i++) begin
      n++;
      step();
    end
    note_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    tests++; if ({pin_clr, note_req, eject, retain} !== 4'b0) begin failed++; $display("FAIL reset_outs got %b exp 0000", {pin_clr, note_req, eject, retain}); end
    tests++; if (msg !== 3'd0) begin failed++; $display("FAIL reset_msg got %0d exp 0", msg); end
    rst = 1'b0; step();
    tests++; if (msg !== 3'd0) begin failed++; $display("FAIL idle_msg got %0d exp 0", msg); end
  endtask

  task automatic test_withdraw();
    card = 1'b1; step();
    tests++; if (pin_clr !== 1'b1 || msg !== 3'd1) begin failed++; $display("FAIL insert got pin_clr=%b msg=%0d exp 1/1", pin_clr, msg); end
    step();
    tests++; if (pin_clr !== 1'b0) begin failed++; $display("FAIL pin_clr_width got %b exp 0", pin_clr); end
    pin_ok = 1'b1; balance = 8'd50; step(); pin_ok = 1'b0;
    tests++; if (msg !== 3'd2) begin failed++; $display("FAIL menu_msg got %0d exp 2", msg); end
    wd_amt = 8'd3; wd_req = 1'b1; step(); wd_req = 1'b0;
    tests++; if (note_req !== 1'b1 || msg !== 3'd4) begin failed++; $display("FAIL disp_start got req=%b msg=%0d exp 1/4", note_req, msg); end
    dispense(cnt);
    tests++; if (cnt !== 3) begin failed++; $display("FAIL notes_3 got %0d exp 3", cnt); end
    tests++; if (msg !== 3'd2 || note_req !== 1'b0) begin failed++; $display("FAIL after_disp got msg=%0d req=%b exp 2/0", msg, note_req); end
    // Remaining balance is 47: 48 is refused.
    wd_amt = 8'd48; wd_req = 1'b1; step(); wd_req = 1'b0;
    tests++; if (msg !== 3'd5 || note_req !== 1'b0) begin failed++; $display("FAIL bal47 got msg=%0d req=%b exp 5/0", msg, note_req); end
    cancel = 1'b1; step(); cancel = 1'b0;
    tests++; if (eject !== 1'b1 || msg !== 3'd6) begin failed++; $display("FAIL cancel_eject got eject=%b msg=%0d exp 1/6", eject, msg); end
    card = 1'b0; step();
    tests++; if (eject !== 1'b0 || msg !== 3'd0) begin failed++; $display("FAIL eject_idle got eject=%b msg=%0d exp 0/0", eject, msg); end
  endtask

  task automatic test_pin_retry();
    card = 1'b1; step(); step();
    pin_bad = 1'b1; step(); pin_bad = 1'b0;
    tests++; if (pin_clr !== 1'b1 || msg !== 3'd3) begin failed++; $display("FAIL bad1 got pin_clr=%b msg=%0d exp 1/3", pin_clr, msg); end
    step();
    tests++; if (pin_clr !== 1'b0 || msg !== 3'd3) begin failed++; $display("FAIL bad1_hold got pin_clr=%b msg=%0d exp 0/3", pin_clr, msg); end
    pin_bad = 1'b1; step(); pin_bad = 1'b0;
    tests++; if (pin_clr !== 1'b1 || msg !== 3'd3) begin failed++; $display("FAIL bad2 got pin_clr=%b msg=%0d exp 1/3", pin_clr, msg); end
    step();
    pin_bad = 1'b1; step(); pin_bad = 1'b0;
    tests++; if (retain !== 1'b1 || msg !== 3'd7 || pin_clr !== 1'b0) begin failed++; $display("FAIL bad3 got retain=%b msg=%0d pin_clr=%b exp 1/7/0", retain, msg, pin_clr); end
    card = 1'b0; cancel = 1'b1; step(); cancel = 1'b0;
    for (int i = 0; i < 15; i++) step();
    tests++; if (retain !== 1'b1 || msg !== 3'd7 || eject !== 1'b0) begin failed++; $display("FAIL retain_hold got retain=%b msg=%0d eject=%b exp 1/7/0", retain, msg, eject); end
    rst = 1'b1; step(); rst = 1'b0;
    tests++; if (retain !== 1'b0 || msg !== 3'd0) begin failed++; $display("FAIL retain_rst got retain=%b msg=%0d exp 0/0", retain, msg); end
  endtask

  task automatic test_nsf();
    login(8'd5);
    wd_amt = 8'd6; wd_req = 1'b1; step(); wd_req = 1'b0;
    tests++; if (msg !== 3'd5 || note_req !== 1'b0) begin failed++; $display("FAIL nsf got msg=%0d req=%b exp 5/0", msg, note_req); end
    wd_amt = 8'd5; wd_req = 1'b1; step(); wd_req = 1'b0;
    tests++; if (msg !== 3'd4 || note_req !== 1'b1) begin failed++; $display("FAIL nsf_ok got msg=%0d req=%b exp 4/1", msg, note_req); end
    dispense(cnt);
    tests++; if (cnt !== 5 || msg !== 3'd2) begin failed++; $display("FAIL notes_5 got n=%0d msg=%0d exp 5/2", cnt, msg); end
    wd_amt = 8'd1; wd_req = 1'b1; step(); wd_req = 1'b0;
    tests++; if (msg !== 3'd5) begin failed++; $display("FAIL bal0 got msg=%0d exp 5", msg); end
    card = 1'b0; step();
    tests++; if (msg !== 3'd0 || eject !== 1'b0) begin failed++; $display("FAIL menu_pull got msg=%0d eject=%b exp 0/0", msg, eject); end
  endtask

  task automatic test_timeout();
    card = 1'b1; step();
    for (int i = 0; i < 10; i++) step();
    tests++; if (eject !== 1'b0 || msg !== 3'd1) begin failed++; $display("FAIL tmo_early got eject=%b msg=%0d exp 0/1", eject, msg); end
    step();
    tests++; if (eject !== 1'b1 || msg !== 3'd6) begin failed++; $display("FAIL tmo got eject=%b msg=%0d exp 1/6", eject, msg); end
    card = 1'b0; step();
    tests++; if (eject !== 1'b0 || msg !== 3'd0) begin failed++; $display("FAIL tmo_idle got eject=%b msg=%0d exp 0/0", eject, msg); end
  endtask

  task automatic test_back_to_back();
    card = 1'b1; step(); step();
    pin_ok = 1'b1; pin_bad = 1'b1; balance = 8'd20; step(); pin_ok = 1'b0; pin_bad = 1'b0;
    tests++; if (msg !== 3'd2 || pin_clr !== 1'b0) begin failed++; $display("FAIL ok_bad got msg=%0d pin_clr=%b exp 2/0", msg, pin_clr); end
    wd_amt = 8'd4; wd_req = 1'b1; cancel = 1'b1; step(); wd_req = 1'b0;
    tests++; if (note_req !== 1'b1 || eject !== 1'b0) begin failed++; $display("FAIL wd_over_cancel got req=%b eject=%b exp 1/0", note_req, eject); end
    step(); cancel = 1'b0;
    tests++; if (note_req !== 1'b1 || msg !== 3'd4) begin failed++; $display("FAIL disp_cancel got req=%b msg=%0d exp 1/4", note_req, msg); end
    dispense(cnt);
    tests++; if (cnt !== 4 || msg !== 3'd2 || eject !== 1'b0) begin failed++; $display("FAIL notes_4 got n=%0d msg=%0d eject=%b exp 4/2/0", cnt, msg, eject); end
    card = 1'b0; step();
  endtask

  task automatic test_rst_in_disp();
    login(8'd9);
    wd_amt = 8'd3; wd_req = 1'b1; step(); wd_req = 1'b0;
    note_ack = 1'b1; step(); note_ack = 1'b0;
    tests++; if (note_req !== 1'b1) begin failed++; $display("FAIL pre_rst got req=%b exp 1", note_req); end
    rst = 1'b1; card = 1'b0; step(); rst = 1'b0;
    tests++; if ({pin_clr, note_req, eject, retain} !== 4'b0 || msg !== 3'd0) begin failed++; $display("FAIL rst_disp got outs=%b msg=%0d exp 0000/0", {pin_clr, note_req, eject, retain}, msg); end
    step();
    tests++; if (note_req !== 1'b0 || msg !== 3'd0) begin failed++; $display("FAIL rst_idle got req=%b msg=%0d exp 0/0", note_req, msg); end
  endtask

  initial begin
    test_reset();
    test_withdraw();
    test_pin_retry();
    test_nsf();
    test_timeout();
    test_back_to_back();
    test_rst_in_disp();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
